// File: rtl/dbchecker_err_responder_pkg.sv
// Shared definitions for the DBChecker error responder.
//   - AXI response encodings (OKAY / SLVERR / DECERR)
//   - ERR_RESP: response code returned on every B and R beat.
//     Selected by macro DBCHECKER_ERR_DECERR_EN (defined -> DECERR, else SLVERR).
//   - Write / read FSM state enums.
package dbchecker_err_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef DBCHECKER_ERR_DECERR_EN
  localparam logic [1:0] ERR_RESP = RESP_DECERR;
`else
  localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`endif

  typedef enum logic [1:0] {
    W_IDLE,
    W_DRAIN,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/dbchecker_sat_cnt.sv
// 32-bit saturating event counter.
//   clock : rising-edge clock
//   reset : synchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   cnt   : current count, holds at 32'hFFFF_FFFF instead of wrapping
module dbchecker_sat_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dbchecker_err_responder.sv
// Error responder for transactions denied by the DBChecker. Every accepted
// AW burst has its W beats drained and is answered with one error B; every
// accepted AR burst is answered with len+1 zero-data error R beats. Write and
// read paths are fully independent.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   s_axi_aw_* / s_axi_w_* / s_axi_b_* : AXI write address / data / response
//   s_axi_ar_* / s_axi_r_*              : AXI read address / data
//   err_wr_cnt, err_rd_cnt : saturating counts of completed denied bursts
//   proto_err              : sticky flag, WLAST disagreed with the beat count
// Configuration macro: DBCHECKER_ERR_DECERR_EN (DECERR instead of SLVERR).
module dbchecker_err_responder
  import dbchecker_err_responder_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_axi_aw_valid,
  output logic              s_axi_aw_ready,
  input  logic [ADDR_W-1:0] s_axi_aw_bits_addr,
  input  logic [7:0]        s_axi_aw_bits_len,
  input  logic              s_axi_w_valid,
  output logic              s_axi_w_ready,
  input  logic              s_axi_w_bits_last,
  output logic              s_axi_b_valid,
  input  logic              s_axi_b_ready,
  output logic [1:0]        s_axi_b_bits_resp,
  input  logic              s_axi_ar_valid,
  output logic              s_axi_ar_ready,
  input  logic [ADDR_W-1:0] s_axi_ar_bits_addr,
  input  logic [7:0]        s_axi_ar_bits_len,
  output logic              s_axi_r_valid,
  input  logic              s_axi_r_ready,
  output logic [DATA_W-1:0] s_axi_r_bits_data,
  output logic [1:0]        s_axi_r_bits_resp,
  output logic              s_axi_r_bits_last,
  output logic [31:0]       err_wr_cnt,
  output logic [31:0]       err_rd_cnt,
  output logic              proto_err
);

  // Addresses are irrelevant to a denied burst.
  logic unused_addr;
  assign unused_addr = ^{s_axi_aw_bits_addr, s_axi_ar_bits_addr};

  w_state_e   w_state_q, w_state_d;
  logic [7:0] wr_len_q, wr_len_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  logic       proto_err_q, proto_err_d;
  r_state_e   r_state_q, r_state_d;
  logic [7:0] rd_len_q, rd_len_d;
  logic [7:0] r_cnt_q, r_cnt_d;

  logic w_final;
  logic r_final;
  logic wr_done;
  logic rd_done;

  assign w_final = (w_cnt_q == wr_len_q);
  assign r_final = (r_cnt_q == rd_len_q);

  // Write path: burst ends on beat count; WLAST is only cross-checked.
  always_comb begin
    w_state_d   = w_state_q;
    wr_len_d    = wr_len_q;
    w_cnt_d     = w_cnt_q;
    proto_err_d = proto_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_aw_valid) begin
          wr_len_d  = s_axi_aw_bits_len;
          w_cnt_d   = '0;
          w_state_d = W_DRAIN;
        end
      end
      W_DRAIN: begin
        if (s_axi_w_valid) begin
          if (s_axi_w_bits_last != w_final) proto_err_d = 1'b1;
          if (w_final) w_state_d = W_RESP;
          else         w_cnt_d   = w_cnt_q + 8'd1;
        end
      end
      W_RESP: begin
        if (s_axi_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_len_d  = rd_len_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_ar_valid) begin
          rd_len_d  = s_axi_ar_bits_len;
          r_cnt_d   = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_r_ready) begin
          if (r_final) r_state_d = R_IDLE;
          else         r_cnt_d   = r_cnt_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      wr_len_q    <= '0;
      w_cnt_q     <= '0;
      proto_err_q <= 1'b0;
      r_state_q   <= R_IDLE;
      rd_len_q    <= '0;
      r_cnt_q     <= '0;
    end else begin
      w_state_q   <= w_state_d;
      wr_len_q    <= wr_len_d;
      w_cnt_q     <= w_cnt_d;
      proto_err_q <= proto_err_d;
      r_state_q   <= r_state_d;
      rd_len_q    <= rd_len_d;
      r_cnt_q     <= r_cnt_d;
    end
  end

  assign s_axi_aw_ready    = (w_state_q == W_IDLE);
  assign s_axi_w_ready     = (w_state_q == W_DRAIN);
  assign s_axi_b_valid     = (w_state_q == W_RESP);
  assign s_axi_b_bits_resp = ERR_RESP;
  assign s_axi_ar_ready    = (r_state_q == R_IDLE);
  assign s_axi_r_valid     = (r_state_q == R_DATA);
  assign s_axi_r_bits_data = '0;
  assign s_axi_r_bits_resp = ERR_RESP;
  assign s_axi_r_bits_last = (r_state_q == R_DATA) && r_final;
  assign proto_err         = proto_err_q;

  assign wr_done = (w_state_q == W_RESP) && s_axi_b_ready;
  assign rd_done = (r_state_q == R_DATA) && s_axi_r_ready && r_final;

  dbchecker_sat_cnt u_wr_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (wr_done),
    .cnt   (err_wr_cnt)
  );

  dbchecker_sat_cnt u_rd_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (rd_done),
    .cnt   (err_rd_cnt)
  );

endmodule
